// File: rtl/pipelined_approx_multiplier.sv
// rtl/pipelined_approx_multiplier.sv - 3-stage pipelined unsigned WIDTHxWIDTH multiplier with per-op approximate low columns
// Optional error monitor enabled by defining APPROX_MULT_ERRMON_EN (adds err_flag and err_count).
module pipelined_approx_multiplier #(
   parameter int WIDTH       = 16,
   parameter int APPROX_COLS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 approx_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   res
`ifdef APPROX_MULT_ERRMON_EN
   ,
   output logic                 err_flag,
   output logic [15:0]          err_count
`endif
);

   localparam int PW = 2 * WIDTH;
   localparam logic [PW-1:0] ONE      = PW'(1);
   // Columns that are OR-compressed when approximate mode is selected.
   localparam logic [PW-1:0] LOW_MASK = (ONE << APPROX_COLS) - ONE;

   // Stage valids and data.
   logic             v1_q, v2_q, v3_q;
   logic [WIDTH-1:0] a1_q, b1_q;
   logic             ap1_q;
   logic [PW-1:0]    s2_q, c2_q, low2_q;
   logic [PW-1:0]    res_q;

   // Next-state values for stage 2 and stage 3.
   logic [PW-1:0]    s2_d, c2_d, low2_d;
   logic [PW-1:0]    res_d;

   logic stall;
   logic adv;

   assign stall     = v3_q & ~out_ready;
   assign adv       = ~stall;
   assign in_ready  = ~stall;
   assign out_valid = v3_q;
   assign res       = res_q;

   // Stage 2 reduction: upper columns accumulate row-by-row in carry-save form;
   // masked low columns only OR together, so they never generate carries.
   always_comb begin
      logic [PW-1:0] mask;
      logic [PW-1:0] row;
      logic [PW-1:0] row_m;
      logic [PW-1:0] maj;
      mask   = ap1_q ? LOW_MASK : '0;
      s2_d   = '0;
      c2_d   = '0;
      low2_d = '0;
      row    = '0;
      row_m  = '0;
      maj    = '0;
      for (int j = 0; j < WIDTH; j++) begin
         row    = PW'(a1_q & {WIDTH{b1_q[j]}}) << j;
         low2_d = low2_d | (row & mask);
         row_m  = row & ~mask;
         maj    = (s2_d & c2_d) | (s2_d & row_m) | (c2_d & row_m);
         s2_d   = s2_d ^ c2_d ^ row_m;
         c2_d   = maj << 1;
      end
   end

   // Stage 3: carry-propagate the upper columns; low sum/carry bits are zero so OR merges the approximate bits.
   always_comb begin
      res_d = (s2_q + c2_q) | low2_q;
   end

   // Stage 1: capture operands and mode; whole pipe freezes while the output is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q  <= 1'b0;
         a1_q  <= '0;
         b1_q  <= '0;
         ap1_q <= 1'b0;
      end else if (adv) begin
         v1_q <= in_valid;
         if (in_valid) begin
            a1_q  <= a;
            b1_q  <= b;
            ap1_q <= approx_en;
         end
      end
   end

   // Stage 2: register carry-save vectors and the approximate low bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_q   <= 1'b0;
         s2_q   <= '0;
         c2_q   <= '0;
         low2_q <= '0;
      end else if (adv) begin
         v2_q <= v1_q;
         if (v1_q) begin
            s2_q   <= s2_d;
            c2_q   <= c2_d;
            low2_q <= low2_d;
         end
      end
   end

   // Stage 3: register the final product; res only changes when a new valid result arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3_q  <= 1'b0;
         res_q <= '0;
      end else if (adv) begin
         v3_q <= v2_q;
         if (v2_q) begin
            res_q <= res_d;
         end
      end
   end

`ifdef APPROX_MULT_ERRMON_EN
   logic [PW-1:0] x2_q;
   logic          flag_q;
   logic [15:0]   cnt_q;

   assign err_flag  = flag_q & v3_q;
   assign err_count = cnt_q;

   // Shadow exact product, kept in step with the main pipe, and the mismatch flag for stage 3.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x2_q   <= '0;
         flag_q <= 1'b0;
      end else if (adv) begin
         if (v1_q) begin
            x2_q <= PW'(a1_q) * PW'(b1_q);
         end
         if (v2_q) begin
            flag_q <= (res_d != x2_q);
         end
      end
   end

   // Saturating count of delivered results that differ from the exact product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (v3_q && out_ready && flag_q && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end
`endif

endmodule
